// File: rtl/line_delay_bank.sv
// line_delay_bank: cascaded line-buffer bank delivering NTAP vertically aligned
// pixels plus a line-delayed status word, with internal column addressing.
// Optional build macro: LINE_DELAY_BORDER_REPLICATE_EN (replicate the oldest
// valid line into taps that have not yet been filled since start of frame).
module line_delay_bank #(
  parameter int DW       = 8,
  parameter int SW       = 1,
  parameter int NTAP     = 5,
  parameter int ADDR_W   = 12,
  parameter int LINE_LEN = 1650,
  parameter int STAT_TAP = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din_valid,
  input  logic                sol,
  input  logic                sof,
  input  logic [DW-1:0]       data_in,
  input  logic [SW-1:0]       stat_in,
  output logic [NTAP*DW-1:0]  taps,
  output logic [SW-1:0]       stat_o,
  output logic                dout_valid,
  output logic [3:0]          lines_filled,
  output logic [ADDR_W-1:0]   col
);

  localparam int NRAM  = NTAP - 1;
  localparam int WW    = DW + SW;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(LINE_LEN - 1);
  localparam logic [ADDR_W-1:0] COL_ONE  = ADDR_W'(1);
  localparam logic [3:0]        LF_MAX   = 4'(NTAP - 1);

  // Line storage: no reset, contents survive reset by design.
  logic [WW-1:0]     mem_r [NRAM][DEPTH];
  logic [WW-1:0]     wr_s  [NRAM];
  logic [WW-1:0]     rd_r  [NRAM];
  logic [WW-1:0]     in_r;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] addr_s;
  logic [ADDR_W-1:0] cnt_next_s;
  logic [ADDR_W-1:0] col_r;
  logic [3:0]        lf_r;
  logic [3:0]        lf_next_s;
  logic              valid_r;
  logic [WW-1:0]     word_s [NTAP];
  logic [WW-1:0]     sel_s  [NTAP];
  logic [WW-1:0]     rep_s;
  logic [NTAP*DW-1:0] taps_s;

  // Column address, next counter value and next line count for this beat.
  always_comb begin
    addr_s     = cnt_r;
    cnt_next_s = cnt_r;
    lf_next_s  = lf_r;
    if (sol || sof) begin
      addr_s = {ADDR_W{1'b0}};
    end else begin
      addr_s = cnt_r;
    end
    if (addr_s == COL_LAST) begin
      cnt_next_s = {ADDR_W{1'b0}};
    end else begin
      cnt_next_s = addr_s + COL_ONE;
    end
    if (sof) begin
      lf_next_s = 4'd0;
    end else if (sol && (lf_r < LF_MAX)) begin
      lf_next_s = lf_r + 4'd1;
    end else begin
      lf_next_s = lf_r;
    end
  end

  // Cascade write data: each RAM takes the old word of the RAM before it.
  always_comb begin
    wr_s[0] = {stat_in, data_in};
    for (int k = 1; k < NRAM; k++) begin
      wr_s[k] = mem_r[k-1][addr_s];
    end
  end

  // Read-first line RAM writes, enabled only on accepted beats.
  always_ff @(posedge clk) begin
    if (din_valid) begin
      for (int k = 0; k < NRAM; k++) begin
        mem_r[k][addr_s] <= wr_s[k];
      end
    end
  end

  // Output-aligned registers, column counter and line count.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_r    <= {WW{1'b0}};
      valid_r <= 1'b0;
      cnt_r   <= {ADDR_W{1'b0}};
      col_r   <= {ADDR_W{1'b0}};
      lf_r    <= 4'd0;
      for (int k = 0; k < NRAM; k++) begin
        rd_r[k] <= {WW{1'b0}};
      end
    end else begin
      valid_r <= din_valid;
      if (din_valid) begin
        in_r  <= {stat_in, data_in};
        cnt_r <= cnt_next_s;
        col_r <= addr_s;
        lf_r  <= lf_next_s;
        for (int k = 0; k < NRAM; k++) begin
          rd_r[k] <= mem_r[k][addr_s];
        end
      end
    end
  end

  // Tap selection (raw, or oldest valid line replicated upward) and packing.
  always_comb begin
    word_s[0] = in_r;
    for (int k = 1; k < NTAP; k++) begin
      word_s[k] = rd_r[k-1];
    end
    rep_s = word_s[0];
    for (int j = 1; j < NTAP; j++) begin
      rep_s = (int'(lf_r) == j) ? word_s[j] : rep_s;
    end
    for (int k = 0; k < NTAP; k++) begin
`ifdef LINE_DELAY_BORDER_REPLICATE_EN
      sel_s[k] = (int'(lf_r) < k) ? rep_s : word_s[k];
`else
      sel_s[k] = word_s[k];
`endif
    end
    taps_s = {(NTAP*DW){1'b0}};
    for (int k = 0; k < NTAP; k++) begin
      taps_s[k*DW +: DW] = sel_s[k][DW-1:0];
    end
  end

  assign taps         = taps_s;
  assign stat_o       = sel_s[STAT_TAP][DW +: SW];
  assign dout_valid   = valid_r;
  assign lines_filled = lf_r;
  assign col          = col_r;

endmodule

// File: tb/tb_line_delay_bank.sv
// Self-checking bench for line_delay_bank (NTAP=5, DW=8, SW=1, LINE_LEN=8).
module tb_line_delay_bank;

  localparam int DW = 8;
  localparam int NTAP = 5;
  localparam int AW = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic            din_valid;
  logic            sol;
  logic            sof;
  logic [DW-1:0]   data_in;
  logic [0:0]      stat_in;
  logic [NTAP*DW-1:0] taps;
  logic [0:0]      stat_o;
  logic            dout_valid;
  logic [3:0]      lines_filled;
  logic [AW-1:0]   col;

  int total = 0;
  int bad = 0;

  line_delay_bank #(
    .DW(DW), .SW(1), .NTAP(NTAP), .ADDR_W(AW), .LINE_LEN(8), .STAT_TAP(2)
  ) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .sol(sol), .sof(sof),
    .data_in(data_in), .stat_in(stat_in), .taps(taps), .stat_o(stat_o),
    .dout_valid(dout_valid), .lines_filled(lines_filled), .col(col)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sof;
    logic        sol;
    logic [7:0]  din;
    logic        st;
    logic [39:0] e_taps;
    logic [3:0]  e_lf;
    logic [11:0] e_col;
    logic        e_stat;
  } vec_t;

  vec_t tbl [48];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, let the posedge capture, settle.
  task automatic cyc(input logic v, input logic f, input logic l,
                     input logic [7:0] d, input logic s);
    @(negedge clk);
    din_valid = v; sof = f; sol = l; data_in = d; stat_in = s;
    @(posedge clk);
    #1;
  endtask

  logic [39:0] exp_t;
  logic [39:0] held;

  initial begin
    rst = 1'b1; din_valid = 1'b0; sol = 1'b0; sof = 1'b0;
    data_in = 8'h00; stat_in = 1'b0;

    // Build the main-frame table: line L, column c, data 16*L+c.
    for (int l = 0; l < 6; l++) begin
      for (int c = 0; c < 8; c++) begin
        int i;
        i = l * 8 + c;
        tbl[i].sof = (l == 0 && c == 0);
        tbl[i].sol = (c == 0);
        tbl[i].din = 8'(16 * l + c);
        tbl[i].st  = (l == 0);
        tbl[i].e_lf = 4'((l < 4) ? l : 4);
        tbl[i].e_col = 12'(c);
        tbl[i].e_taps = 40'h0;
        for (int k = 0; k < NTAP; k++) begin
          if (l >= k) tbl[i].e_taps[k*8 +: 8] = 8'(16 * (l - k) + c);
`ifdef LINE_DELAY_BORDER_REPLICATE_EN
          else tbl[i].e_taps[k*8 +: 8] = 8'(c);
`else
          else tbl[i].e_taps[k*8 +: 8] = 8'hFF;
`endif
        end
`ifdef LINE_DELAY_BORDER_REPLICATE_EN
        tbl[i].e_stat = (l >= 2) ? (l == 2) : 1'b1;
`else
        tbl[i].e_stat = (l == 2);
`endif
      end
    end

    // Reset held, then idle.
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("idle_taps", taps, 64'h0);
      chk("idle_valid", dout_valid, 64'h0);
      chk("idle_lf", lines_filled, 64'h0);
    end
    // First beat after reset without sol lands at column 0.
    cyc(1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);
    chk("first_col", col, 64'h0);
    chk("first_valid", dout_valid, 64'h1);
    chk("first_tap0", taps[7:0], 64'hA5);

    // Fill frame: 6 lines of 0xFF with status 0.
    for (int l = 0; l < 6; l++) begin
      for (int c = 0; c < 8; c++) begin
        cyc(1'b1, (l == 0 && c == 0), (c == 0), 8'hFF, 1'b0);
      end
    end

    // Main frame, continuous valid, table-driven.
    for (int i = 0; i < 48; i++) begin
      cyc(1'b1, tbl[i].sof, tbl[i].sol, tbl[i].din, tbl[i].st);
      chk("tbl_taps", taps, tbl[i].e_taps);
      chk("tbl_lf", lines_filled, tbl[i].e_lf);
      chk("tbl_col", col, tbl[i].e_col);
      chk("tbl_stat", stat_o, tbl[i].e_stat);
      chk("tbl_valid", dout_valid, 64'h1);
    end

    // Line 6 with stalls after columns 3 and 4 (pattern 1,0,1,0).
    for (int c = 0; c < 8; c++) begin
      cyc(1'b1, 1'b0, (c == 0), 8'(96 + c), 1'b0);
      for (int k = 0; k < NTAP; k++) exp_t[k*8 +: 8] = 8'(16 * (6 - k) + c);
      chk("stall_taps", taps, exp_t);
      chk("stall_col", col, 64'(c));
      chk("stall_lf", lines_filled, 64'h4);
      if (c == 3 || c == 4) begin
        held = exp_t;
        cyc(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1);
        chk("gap_valid", dout_valid, 64'h0);
        chk("gap_taps", taps, held);
        chk("gap_col", col, 64'(c));
      end
    end

    // Wrap: sof then 9 beats without sol -> 0..7,0,1.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, (i == 0), (i == 0), 8'(i), 1'b0);
      chk("wrap_col", col, 64'(i % 8));
      chk("wrap_lf", lines_filled, 64'h0);
    end
    for (int c = 2; c < 6; c++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'(c), 1'b0);
      chk("pre_sol_col", col, 64'(c));
    end
    cyc(1'b1, 1'b0, 1'b1, 8'h30, 1'b0);
    chk("early_sol_col", col, 64'h0);
    chk("early_sol_lf", lines_filled, 64'h1);
    cyc(1'b1, 1'b0, 1'b0, 8'h31, 1'b0);
    chk("after_sol_col", col, 64'h1);

    // sol/sof without valid are ignored.
    cyc(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h32, 1'b0);
    chk("ign_col", col, 64'h2);
    chk("ign_lf", lines_filled, 64'h1);

    // Reset mid-line, then a beat without sol.
    @(negedge clk); rst = 1'b1; din_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_taps", taps, 64'h0);
    chk("rst_valid", dout_valid, 64'h0);
    chk("rst_lf", lines_filled, 64'h0);
    @(negedge clk); rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 8'h5A, 1'b0);
    chk("rst_beat_col", col, 64'h0);
    chk("rst_beat_lf", lines_filled, 64'h0);
    chk("rst_beat_tap0", taps[7:0], 64'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
